afl_load_sequencer: RTL and testbench

//   Sequences tile loads into aligned_feature_loader (AFL). Accepts a feature word stream
//   (valid/ready), assigns per-word AFL address offsets, drives AFL load-direction codes,
//   and shifts loaded columns across the aflDimX array. Sits between the feature

---
 rtl/afl_load_sequencer.sv | 122 ++++++++++++
 tb/tb_afl_load_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/afl_load_sequencer.sv
// Tile load sequencer for the aligned feature loader: streams feature words into
// AFL columns with per-word address offsets and inserts a shift between columns.
module afl_load_sequencer #(
    parameter int AFL_DIM_Y     = 128,
    parameter int AFL_DIM_X     = 6,
    parameter int INPUT_WIDTH   = 32,
    parameter int ELEMENT_WIDTH = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int COL_W         = $clog2(AFL_DIM_X + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [COL_W-1:0]       num_cols_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [COL_W-1:0]       cols_loaded_o,
    input  logic [INPUT_WIDTH-1:0] src_data_i,
    input  logic                   src_valid_i,
    output logic                   src_ready_o,
    output logic [INPUT_WIDTH-1:0] afl_data_o,
    output logic                   afl_valid_o,
    output logic [ADDR_WIDTH-1:0]  afl_addr_o,
    output logic [1:0]             afl_dir_o
);

    localparam int WORDS_PER_COL = AFL_DIM_Y * ELEMENT_WIDTH / INPUT_WIDTH;
    localparam int WORD_W = $clog2(WORDS_PER_COL);
    localparam logic [COL_W-1:0] MAX_COLS = COL_W'(AFL_DIM_X);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_COL - 1);

    localparam logic [1:0] DIR_HOLD  = 2'b00;
    localparam logic [1:0] DIR_LOAD  = 2'b01;
    localparam logic [1:0] DIR_SHIFT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  ncols;
    logic [COL_W-1:0]  ncols_clamped;
    logic [WORD_W-1:0] word_cnt;
    logic              beat;
    logic              last_word;
    logic              more_cols;

    assign src_ready_o   = (state == S_LOAD);
    assign beat          = src_valid_i & src_ready_o;
    assign last_word     = (word_cnt == LAST_WORD);
    assign more_cols     = ((cols_loaded_o + COL_W'(1)) < ncols);
    assign ncols_clamped = (num_cols_i > MAX_COLS) ? MAX_COLS : num_cols_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            ncols         <= '0;
            word_cnt      <= '0;
            cols_loaded_o <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            afl_data_o    <= '0;
            afl_valid_o   <= 1'b0;
            afl_addr_o    <= '0;
            afl_dir_o     <= DIR_HOLD;
        end else begin
            afl_valid_o <= 1'b0;
            afl_dir_o   <= DIR_HOLD;
            done_o      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        ncols         <= ncols_clamped;
                        word_cnt      <= '0;
                        cols_loaded_o <= '0;
                        busy_o        <= 1'b1;
                        if (ncols_clamped == '0) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        afl_valid_o <= 1'b1;
                        afl_data_o  <= src_data_i;
                        afl_addr_o  <= ADDR_WIDTH'(word_cnt);
                        afl_dir_o   <= DIR_LOAD;
                        if (last_word) begin
                            word_cnt      <= '0;
                            cols_loaded_o <= cols_loaded_o + COL_W'(1);
                            if (more_cols) begin
                                state <= S_SHIFT;
                            end else begin
                                state  <= S_DONE;
                                done_o <= 1'b1;
                            end
                        end else begin
                            word_cnt <= word_cnt + WORD_W'(1);
                        end
                    end
                end
                S_SHIFT: begin
                    afl_dir_o  <= DIR_SHIFT;
                    afl_addr_o <= '0;
                    state      <= S_LOAD;
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_afl_load_sequencer.sv
// Directed bench for afl_load_sequencer: vector table for short cycle-exact
// sequences plus scoreboarded multi-column tiles.
module tb_afl_load_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  num_cols_i;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  cols_loaded_o;
    logic [31:0] src_data_i;
    logic        src_valid_i;
    logic        src_ready_o;
    logic [31:0] afl_data_o;
    logic        afl_valid_o;
    logic [31:0] afl_addr_o;
    logic [1:0]  afl_dir_o;

    int          total = 0;
    int          passed = 0;
    logic [31:0] data_base = 32'h1000_0000;

    afl_load_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .num_cols_i   (num_cols_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cols_loaded_o(cols_loaded_o),
        .src_data_i   (src_data_i),
        .src_valid_i  (src_valid_i),
        .src_ready_o  (src_ready_o),
        .afl_data_o   (afl_data_o),
        .afl_valid_o  (afl_valid_o),
        .afl_addr_o   (afl_addr_o),
        .afl_dir_o    (afl_dir_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [2:0]  ncols;
        logic        valid;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic        ready;
        logic        avalid;
        logic [1:0]  dir;
        logic [31:0] addr;
        logic [31:0] adata;
        logic [2:0]  cols;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_i = 1'b0;
        num_cols_i = '0;
        src_valid_i = 1'b0;
        src_data_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_tile(input int req, input int pct, input bit poke);
        int n;
        int sent = 0;
        int shifts = 0;
        int dones = 0;
        int cyc = 0;
        bit exp_shift = 1'b0;
        bit beat;
        bit finished = 1'b0;
        logic [31:0] base;
        n = (req > 6) ? 6 : req;
        base = data_base;
        src_valid_i = 1'b0;
        start_i = 1'b1;
        num_cols_i = 3'(req);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        chk("start_busy", busy_o, 1);
        chk("start_cols", cols_loaded_o, 0);
        if (n == 0) begin
            chk("zero_done", done_o, 1);
            chk("zero_ready", src_ready_o, 0);
            chk("zero_valid", afl_valid_o, 0);
            @(posedge clk);
            #1;
            chk("zero_idle", busy_o, 0);
            chk("zero_done_drop", done_o, 0);
            chk("zero_no_write", afl_valid_o, 0);
            return;
        end
        chk("start_ready", src_ready_o, 1);
        chk("start_no_done", done_o, 0);
        while (!finished && cyc < 2000) begin
            cyc++;
            src_valid_i = ($urandom_range(99) < pct);
            src_data_i = base + 32'(sent);
            if (poke && (cyc == 20 || cyc == 21)) begin
                start_i = 1'b1;
                num_cols_i = 3'd1;
            end else begin
                start_i = 1'b0;
            end
            beat = src_valid_i && src_ready_o;
            @(posedge clk);
            #1;
            if (beat) begin
                chk("load_valid", afl_valid_o, 1);
                chk("load_dir", afl_dir_o, 2'b01);
                chk("load_data", afl_data_o, base + 32'(sent));
                chk("load_addr", afl_addr_o, sent % 16);
                sent++;
            end else begin
                chk("idle_valid", afl_valid_o, 0);
                chk("idle_dir", afl_dir_o, exp_shift ? 2'b10 : 2'b00);
                if (exp_shift) chk("shift_addr", afl_addr_o, 0);
            end
            if (afl_dir_o == 2'b10) shifts++;
            if (done_o) dones++;
            exp_shift = beat && (sent % 16 == 0) && (sent < 16 * n);
            finished = beat && (sent == 16 * n);
            chk("ready", src_ready_o, 1'(!(beat && (sent % 16 == 0))));
            chk("done", done_o, 1'(finished));
            chk("cols", cols_loaded_o, sent / 16);
        end
        src_valid_i = 1'b0;
        start_i = 1'b0;
        if (!finished) chk("tile_timeout", 0, 1);
        chk("shift_count", shifts, n - 1);
        chk("done_count", dones, 1);
        @(posedge clk);
        #1;
        chk("end_busy", busy_o, 0);
        chk("end_done", done_o, 0);
        chk("end_cols", cols_loaded_o, n);
        chk("end_dir", afl_dir_o, 2'b00);
        chk("end_ready", src_ready_o, 0);
        data_base += 32'(16 * n);
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{0, 0, 0, 32'h00, 0, 0, 0, 0, 2'b00, 0, 32'h00, 0};
        vt[1] = '{1, 0, 0, 32'h00, 1, 1, 0, 0, 2'b00, 0, 32'h00, 0};
        vt[2] = '{0, 0, 0, 32'h00, 0, 0, 0, 0, 2'b00, 0, 32'h00, 0};
        vt[3] = '{1, 1, 1, 32'hAA, 1, 0, 1, 0, 2'b00, 0, 32'h00, 0};
        vt[4] = '{0, 0, 1, 32'h11, 1, 0, 1, 1, 2'b01, 0, 32'h11, 0};
        vt[5] = '{0, 0, 0, 32'h00, 1, 0, 1, 0, 2'b00, 0, 32'h11, 0};
        vt[6] = '{1, 5, 1, 32'h22, 1, 0, 1, 1, 2'b01, 1, 32'h22, 0};
        vt[7] = '{0, 0, 1, 32'h33, 1, 0, 1, 1, 2'b01, 2, 32'h33, 0};

        rst = 1'b1;
        start_i = 1'b0;
        num_cols_i = '0;
        src_valid_i = 1'b0;
        src_data_i = '0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ready", src_ready_o, 0);
        chk("rst_valid", afl_valid_o, 0);
        chk("rst_dir", afl_dir_o, 0);
        chk("rst_addr", afl_addr_o, 0);
        chk("rst_data", afl_data_o, 0);
        chk("rst_cols", cols_loaded_o, 0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            start_i = vt[i].start;
            num_cols_i = vt[i].ncols;
            src_valid_i = vt[i].valid;
            src_data_i = vt[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_busy", i), busy_o, vt[i].busy);
            chk($sformatf("vec%0d_done", i), done_o, vt[i].done);
            chk($sformatf("vec%0d_ready", i), src_ready_o, vt[i].ready);
            chk($sformatf("vec%0d_valid", i), afl_valid_o, vt[i].avalid);
            chk($sformatf("vec%0d_dir", i), afl_dir_o, vt[i].dir);
            chk($sformatf("vec%0d_addr", i), afl_addr_o, vt[i].addr);
            chk($sformatf("vec%0d_data", i), afl_data_o, vt[i].adata);
            chk($sformatf("vec%0d_cols", i), cols_loaded_o, vt[i].cols);
        end
        do_reset();

        run_tile(1, 100, 1'b0);
        run_tile(6, 100, 1'b0);
        run_tile(3, 50, 1'b0);
        run_tile(7, 100, 1'b0);
        run_tile(0, 100, 1'b0);
        run_tile(4, 70, 1'b1);

        begin
            int sent = 0;
            int cyc = 0;
            start_i = 1'b1;
            num_cols_i = 3'd3;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            while (sent < 23 && cyc < 200) begin
                cyc++;
                src_valid_i = 1'b1;
                src_data_i = 32'hC000_0000 + 32'(sent);
                if (src_ready_o) sent++;
                @(posedge clk);
                #1;
            end
            src_valid_i = 1'b0;
            if (sent < 23) chk("mid_timeout", sent, 23);
            chk("mid_pre_valid", afl_valid_o, 1);
            chk("mid_pre_addr", afl_addr_o, 6);
            chk("mid_pre_cols", cols_loaded_o, 1);
            rst = 1'b1;
            #1;
            chk("mid_rst_valid", afl_valid_o, 0);
            chk("mid_rst_dir", afl_dir_o, 0);
            chk("mid_rst_addr", afl_addr_o, 0);
            chk("mid_rst_data", afl_data_o, 0);
            chk("mid_rst_busy", busy_o, 0);
            chk("mid_rst_ready", src_ready_o, 0);
            chk("mid_rst_cols", cols_loaded_o, 0);
            @(posedge clk);
            #1 rst = 1'b0;
        end
        run_tile(2, 60, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
